// File: rtl/iomem_router_pkg.sv
// iomem_router_pkg: shared types and constants for the PicoSoC iomem router.
// Holds the FSM state encoding, slave indices, decode bit positions,
// the default GPIO page, and a one-hot read-data pick helper.
package iomem_router_pkg;

    localparam int NSLV = 3;

    localparam int SLV_VGA  = 0;
    localparam int SLV_DAC  = 1;
    localparam int SLV_GPIO = 2;

    // Decode looks only at the top address byte; these are absolute bit numbers.
    localparam int DEC_VGA_BIT = 31;
    localparam int DEC_DAC_BIT = 30;

    localparam logic [7:0] GPIO_PAGE_DEF = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // OR-mux of packed per-slave read words under a one-hot select.
    function automatic logic [31:0] pick_word(input logic [NSLV*32-1:0] words,
                                              input logic [NSLV-1:0]    onehot);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < NSLV; i++) begin
            w = w | (words[32*i +: 32] & {32{onehot[i]}});
        end
        return w;
    endfunction

endpackage

// File: rtl/iomem_router_if.sv
// iomem_router_if: CPU iomem port plus the peripheral fan-out bus.
// modport slave  = the router's view; modport master = the CPU/peripheral side.
interface iomem_router_if;
    import iomem_router_pkg::*;

    logic                 iomem_valid;
    logic                 iomem_ready;
    logic [3:0]           iomem_wstrb;
    logic [31:0]          iomem_addr;
    logic [31:0]          iomem_wdata;
    logic [31:0]          iomem_rdata;
    logic [NSLV-1:0]      slv_sel;
    logic [23:0]          slv_addr;
    logic [3:0]           slv_wstrb;
    logic [31:0]          slv_wdata;
    logic [NSLV-1:0]      slv_ready;
    logic [NSLV*32-1:0]   slv_rdata;
    logic                 bus_err;
    logic [7:0]           err_cnt;

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, slv_ready, slv_rdata,
        output iomem_ready, iomem_rdata, slv_sel, slv_addr, slv_wstrb, slv_wdata,
               bus_err, err_cnt
    );

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, slv_ready, slv_rdata,
        input  iomem_ready, iomem_rdata, slv_sel, slv_addr, slv_wstrb, slv_wdata,
               bus_err, err_cnt
    );

endinterface

// File: rtl/iomem_router_decode.sv
// iomem_router_decode: combinational address page -> {hit, one-hot slave}.
// Priority: bit 31 (VGA) over bit 30 (DAC) over an exact GPIO page match.
module iomem_router_decode
    import iomem_router_pkg::*;
#(
    parameter logic [7:0] GPIO_PAGE = GPIO_PAGE_DEF
) (
    input  logic [7:0]      page,
    output logic            hit,
    output logic [NSLV-1:0] sel
);

    // Priority decode of the top address byte.
    always_comb begin
        sel = '0;
        if (page[DEC_VGA_BIT-24])
            sel[SLV_VGA] = 1'b1;
        else if (page[DEC_DAC_BIT-24])
            sel[SLV_DAC] = 1'b1;
        else if (page == GPIO_PAGE)
            sel[SLV_GPIO] = 1'b1;
    end

    assign hit = |sel;

endmodule

// File: rtl/iomem_router.sv
// iomem_router: sequences PicoSoC iomem transactions onto VGA/DAC/GPIO.
// IDLE accepts and decodes, ACCESS waits for the selected slave, DONE emits
// the single ready pulse and ignores valid so a retiring request is not re-acked.
// Optional macro IOMEM_TIMEOUT_EN adds a forced-completion counter in ACCESS.
module iomem_router
    import iomem_router_pkg::*;
#(
    parameter logic [7:0]  GPIO_PAGE      = GPIO_PAGE_DEF,
`ifdef IOMEM_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES = 1024,
`endif
    parameter logic [31:0] ERR_RDATA      = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    iomem_router_if.slave bus
);

    state_t          state_q, state_d;
    logic [NSLV-1:0] sel_q, sel_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [23:0]     addr_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     wdata_q;
    logic [7:0]      err_cnt_q;
    logic            accept;

    logic            dec_hit;
    logic [NSLV-1:0] dec_sel;
    logic            sel_ready;
    logic [31:0]     sel_rdata;
    logic            to_expire;

    iomem_router_decode #(.GPIO_PAGE(GPIO_PAGE)) u_decode (
        .page (bus.iomem_addr[31:24]),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Only the latched target's ready/rdata matter; strays from others are masked.
    assign sel_ready = |(bus.slv_ready & sel_q);
    assign sel_rdata = pick_word(bus.slv_rdata, sel_q);

`ifdef IOMEM_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    assign to_expire = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Cycles spent in ACCESS; held at zero elsewhere so it is clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_cnt_q <= '0;
        else if (state_q != ST_ACCESS)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 16'd1;
    end
`else
    assign to_expire = 1'b0;
`endif

    // Next-state, registered-output and latch-enable decisions.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iomem_valid) begin
                    if (dec_hit) begin
                        accept  = 1'b1;
                        sel_d   = dec_sel;
                        state_d = ST_ACCESS;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                if (!bus.iomem_valid) begin
                    // CPU withdrew the request: cancel silently.
                    sel_d   = '0;
                    state_d = ST_IDLE;
                end else if (sel_ready) begin
                    // Slave ready beats a same-cycle timeout expiry.
                    ready_d = 1'b1;
                    rdata_d = sel_rdata;
                    sel_d   = '0;
                    state_d = ST_DONE;
                end else if (to_expire) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    sel_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered CPU-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Request latches; held until the next accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.iomem_addr[23:0];
            wstrb_q <= bus.iomem_wstrb;
            wdata_q <= bus.iomem_wdata;
        end
    end

    // Saturating error counter, stepped alongside each bus_err pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt_q <= '0;
        else if (err_d && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign bus.slv_sel     = sel_q;
    assign bus.slv_addr    = addr_q;
    assign bus.slv_wstrb   = wstrb_q;
    assign bus.slv_wdata   = wdata_q;
    assign bus.bus_err     = err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_iomem_router.sv
// tb_iomem_router: directed self-checking bench for iomem_router.
module tb_iomem_router;
    import iomem_router_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nbad = 0;

    logic            ref_hit;
    logic [NSLV-1:0] ref_sel;

    iomem_router_if bus();

    iomem_router #(
`ifdef IOMEM_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .GPIO_PAGE(8'h03),
        .ERR_RDATA(32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    iomem_router_decode #(.GPIO_PAGE(8'h03)) u_ref (
        .page (bus.iomem_addr[31:24]),
        .hit  (ref_hit),
        .sel  (ref_sel)
    );

    always #5 clk = ~clk;

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        bus.slv_ready   = '0;
        bus.slv_rdata   = {32'hC0C0_C0C0, 32'hB0B0_B0B0, 32'hA0A0_A0A0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_bus();
        tick(); tick();
        nvec++; if (bus.iomem_ready !== 1'b0) begin nbad++; $display("FAIL rst_ready got %b exp 0", bus.iomem_ready); end
        nvec++; if (bus.slv_sel !== 3'b000) begin nbad++; $display("FAIL rst_sel got %b exp 000", bus.slv_sel); end
        nvec++; if (bus.err_cnt !== 8'h00 || bus.bus_err !== 1'b0) begin nbad++; $display("FAIL rst_err got cnt=%h err=%b exp 00/0", bus.err_cnt, bus.bus_err); end
        nvec++; if (bus.iomem_rdata !== 32'h0 || bus.slv_addr !== 24'h0) begin nbad++; $display("FAIL rst_data got rdata=%h addr=%h exp 0/0", bus.iomem_rdata, bus.slv_addr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_gpio_write();
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h0300_0000;
        bus.iomem_wstrb = 4'hF; bus.iomem_wdata = 32'h0000_00A5;
        bus.slv_rdata   = {32'hDEAD_BEEF, 32'hB0B0_B0B0, 32'hA0A0_A0A0};
        tick(); // cycle 1
        nvec++; if (bus.slv_sel !== 3'b100) begin nbad++; $display("FAIL gpio_sel got %b exp 100", bus.slv_sel); end
        nvec++; if (bus.slv_wstrb !== 4'hF || bus.slv_wdata !== 32'hA5) begin nbad++; $display("FAIL gpio_latch got %h/%h exp f/a5", bus.slv_wstrb, bus.slv_wdata); end
        nvec++; if (bus.iomem_ready !== 1'b0) begin nbad++; $display("FAIL gpio_early got %b exp 0", bus.iomem_ready); end
        bus.slv_ready = 3'b100;
        tick(); // cycle 2
        nvec++; if (bus.iomem_ready !== 1'b1 || bus.slv_sel !== 3'b000) begin nbad++; $display("FAIL gpio_done got rdy=%b sel=%b exp 1/000", bus.iomem_ready, bus.slv_sel); end
        nvec++; if (bus.iomem_rdata !== 32'hDEAD_BEEF) begin nbad++; $display("FAIL gpio_rdata got %h exp deadbeef", bus.iomem_rdata); end
        bus.iomem_valid = 1'b0; bus.slv_ready = '0;
        tick(); // cycle 3
        nvec++; if (bus.iomem_ready !== 1'b0 || bus.bus_err !== 1'b0) begin nbad++; $display("FAIL gpio_single got rdy=%b err=%b exp 0/0", bus.iomem_ready, bus.bus_err); end
        tick();
    endtask

    task automatic test_vga_read();
        int pulses = 0;
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h8000_0010; bus.iomem_wstrb = 4'h0;
        bus.slv_rdata   = {32'hC0C0_C0C0, 32'hB0B0_B0B0, 32'h1234_5678};
        for (int c = 1; c <= 9; c++) begin
            tick(); // cycle c
            if (c == 1) begin
                nvec++; if (bus.slv_addr !== 24'h000010 || bus.slv_sel !== 3'b001) begin nbad++; $display("FAIL vga_addr got %h/%b exp 000010/001", bus.slv_addr, bus.slv_sel); end
            end
            if (bus.iomem_ready === 1'b1) begin
                pulses++;
                nvec++; if (c != 6) begin nbad++; $display("FAIL vga_latency got cycle %0d exp 6", c); end
                nvec++; if (bus.iomem_rdata !== 32'h1234_5678) begin nbad++; $display("FAIL vga_rdata got %h exp 12345678", bus.iomem_rdata); end
                bus.iomem_valid = 1'b0;
                bus.slv_rdata   = {32'hC0C0_C0C0, 32'hB0B0_B0B0, 32'h5555_5555};
            end
            bus.slv_ready = (c == 5) ? 3'b001 : 3'b000;
        end
        bus.iomem_valid = 1'b0;
        nvec++; if (pulses != 1) begin nbad++; $display("FAIL vga_pulses got %0d exp 1", pulses); end
        nvec++; if (bus.iomem_rdata !== 32'h1234_5678) begin nbad++; $display("FAIL vga_hold got %h exp 12345678", bus.iomem_rdata); end
    endtask

    task automatic test_unmapped();
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h0500_0000; bus.iomem_wstrb = 4'h0;
        #1;
        nvec++; if (ref_hit !== 1'b0) begin nbad++; $display("FAIL unmap_ref got hit=%b exp 0", ref_hit); end
        tick(); // cycle 1
        nvec++; if (bus.iomem_ready !== 1'b1 || bus.bus_err !== 1'b1) begin nbad++; $display("FAIL unmap_resp got rdy=%b err=%b exp 1/1", bus.iomem_ready, bus.bus_err); end
        nvec++; if (bus.iomem_rdata !== 32'h0 || bus.slv_sel !== 3'b000) begin nbad++; $display("FAIL unmap_data got rdata=%h sel=%b exp 0/000", bus.iomem_rdata, bus.slv_sel); end
        bus.iomem_valid = 1'b0;
        tick(); // cycle 2
        nvec++; if (bus.iomem_ready !== 1'b0 || bus.bus_err !== 1'b0 || bus.err_cnt !== 8'd1) begin nbad++; $display("FAIL unmap_after got rdy=%b err=%b cnt=%0d exp 0/0/1", bus.iomem_ready, bus.bus_err, bus.err_cnt); end
        tick();
    endtask

    task automatic test_priority();
        int pulses = 0;
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'hC300_0000; bus.iomem_wstrb = 4'h0;
        bus.slv_rdata   = {32'hC0C0_C0C0, 32'hB0B0_B0B0, 32'h0BAD_F00D};
        #1;
        nvec++; if (ref_sel !== 3'b001) begin nbad++; $display("FAIL prio_ref got %b exp 001", ref_sel); end
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                nvec++; if (bus.slv_sel !== 3'b001) begin nbad++; $display("FAIL prio_sel got %b exp 001", bus.slv_sel); end
            end
            if (bus.iomem_ready === 1'b1) begin
                pulses++;
                nvec++; if (c != 4 || bus.iomem_rdata !== 32'h0BAD_F00D) begin nbad++; $display("FAIL prio_resp got cycle %0d rdata %h exp 4/0badf00d", c, bus.iomem_rdata); end
                bus.iomem_valid = 1'b0;
            end
            bus.slv_ready = (c <= 2) ? 3'b010 : ((c == 3) ? 3'b001 : 3'b000);
        end
        bus.iomem_valid = 1'b0;
        nvec++; if (pulses != 1) begin nbad++; $display("FAIL prio_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] seen = '0;
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h0300_0040; bus.iomem_wstrb = 4'h0;
        bus.slv_ready   = 3'b100;
        for (int c = 1; c <= 6; c++) begin
            tick();
            seen[c] = bus.iomem_ready;
        end
        bus.iomem_valid = 1'b0; bus.slv_ready = '0;
        nvec++; if (seen[6:1] !== 6'b010010) begin nbad++; $display("FAIL b2b_pulses got %b exp 010010", seen[6:1]); end
        tick(); tick();
        nvec++; if (bus.iomem_ready !== 1'b0 || bus.err_cnt !== 8'd1) begin nbad++; $display("FAIL b2b_idle got rdy=%b cnt=%0d exp 0/1", bus.iomem_ready, bus.err_cnt); end
    endtask

    task automatic test_abort();
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h4000_0000; bus.iomem_wstrb = 4'h0;
        tick(); // cycle 1
        nvec++; if (bus.slv_sel !== 3'b010) begin nbad++; $display("FAIL abort_sel got %b exp 010", bus.slv_sel); end
        bus.iomem_valid = 1'b0;
        tick(); // cycle 2
        nvec++; if (bus.slv_sel !== 3'b000 || bus.iomem_ready !== 1'b0) begin nbad++; $display("FAIL abort_clr got sel=%b rdy=%b exp 000/0", bus.slv_sel, bus.iomem_ready); end
        tick();
        nvec++; if (bus.iomem_ready !== 1'b0 || bus.bus_err !== 1'b0) begin nbad++; $display("FAIL abort_quiet got rdy=%b err=%b exp 0/0", bus.iomem_ready, bus.bus_err); end
    endtask

`ifdef IOMEM_TIMEOUT_EN
    task automatic test_timeout();
        int at = -1;
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h4000_0000; bus.iomem_wstrb = 4'h0;
        bus.slv_ready   = '0;
        for (int c = 1; c <= 40 && at < 0; c++) begin
            tick();
            if (bus.iomem_ready === 1'b1) begin
                at = c;
                nvec++; if (bus.bus_err !== 1'b1 || bus.iomem_rdata !== 32'h0) begin nbad++; $display("FAIL tmo_resp got err=%b rdata=%h exp 1/0", bus.bus_err, bus.iomem_rdata); end
                bus.iomem_valid = 1'b0;
            end
        end
        bus.iomem_valid = 1'b0;
        nvec++; if (at != 17) begin nbad++; $display("FAIL tmo_cycle got %0d exp 17", at); end
        tick(); tick();
    endtask
`endif

    task automatic test_reset_mid();
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h0300_0000; bus.iomem_wstrb = 4'h0;
        tick(); // cycle 1, in ACCESS
        nvec++; if (bus.slv_sel !== 3'b100) begin nbad++; $display("FAIL rmid_pre got %b exp 100", bus.slv_sel); end
        reset = 1'b1;
        #1;
        nvec++; if (bus.slv_sel !== 3'b000 || bus.iomem_ready !== 1'b0) begin nbad++; $display("FAIL rmid_async got sel=%b rdy=%b exp 000/0", bus.slv_sel, bus.iomem_ready); end
        bus.iomem_valid = 1'b0;
        tick(); tick();
        nvec++; if (bus.iomem_ready !== 1'b0 || bus.err_cnt !== 8'd0) begin nbad++; $display("FAIL rmid_hold got rdy=%b cnt=%0d exp 0/0", bus.iomem_ready, bus.err_cnt); end
        reset = 1'b0;
        tick();
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h0300_0004;
        bus.slv_rdata   = {32'h7777_0001, 32'hB0B0_B0B0, 32'hA0A0_A0A0};
        tick(); // cycle 1
        bus.slv_ready = 3'b100;
        tick(); // cycle 2
        nvec++; if (bus.iomem_ready !== 1'b1 || bus.iomem_rdata !== 32'h7777_0001) begin nbad++; $display("FAIL rmid_next got rdy=%b rdata=%h exp 1/77770001", bus.iomem_ready, bus.iomem_rdata); end
        bus.iomem_valid = 1'b0; bus.slv_ready = '0;
        tick(); tick();
    endtask

    task automatic test_saturate();
        bus.iomem_addr = 32'h0500_0000; bus.iomem_wstrb = 4'h0;
        for (int n = 1; n <= 300; n++) begin
            bus.iomem_valid = 1'b1;
            tick();
            bus.iomem_valid = 1'b0;
            tick();
            if (n == 254) begin
                nvec++; if (bus.err_cnt !== 8'hFE) begin nbad++; $display("FAIL sat_254 got %h exp fe", bus.err_cnt); end
            end
            if (n == 255) begin
                nvec++; if (bus.err_cnt !== 8'hFF) begin nbad++; $display("FAIL sat_255 got %h exp ff", bus.err_cnt); end
            end
            tick();
        end
        nvec++; if (bus.err_cnt !== 8'hFF) begin nbad++; $display("FAIL sat_hold got %h exp ff", bus.err_cnt); end
    endtask

    initial begin
        test_reset();
        test_gpio_write();
        test_vga_read();
        test_unmapped();
        test_priority();
        test_back_to_back();
        test_abort();
`ifdef IOMEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    // Hard stop in case the run wedges somewhere unexpected.
    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d vectors", nvec);
        $fatal(1, "watchdog");
    end

endmodule
